// File: rtl/iob_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : iob_bus_arbiter
// Description : Two-master to one-slave arbiter for the IOb native interface.
//               Master 0 is the PicoRV32 instruction bus and master 1 is the
//               data bus. The shared slave port sees the granted master's
//               request combinationally. At most one read is outstanding,
//               and its response is steered back to the master that issued
//               it. Writes complete on acceptance and produce no response.
//
// Ports       : clk_i, rst_n_i (async active-low), cke_i (clock enable)
//               m0_* / m1_* : master request (avalid/addr/wdata/wstrb in,
//                             rdata/rvalid/ready out)
//               s_*         : slave request out, response/ready in
//
// Option      : IOB_BUS_ARBITER_ROUND_ROBIN_EN
//               undefined -> fixed priority, master 1 over master 0
//               defined   -> contended grants alternate, tracked by a
//                            last-grant register
//
// Revision    : 1.0 - initial release
// ============================================================================
module iob_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                cke_i,

    input  logic                m0_avalid_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_rvalid_o,
    output logic                m0_ready_o,

    input  logic                m1_avalid_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_rvalid_o,
    output logic                m1_ready_o,

    output logic                s_avalid_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic [DATA_W-1:0]   s_rdata_i,
    input  logic                s_rvalid_i,
    input  logic                s_ready_i
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_owner;
    logic   w_owner_next;

    logic   w_en;
    logic   w_idle;
    logic   w_any_req;
    logic   w_gnt;
    logic   w_gnt_avalid;
    logic   w_gnt_is_read;
    logic   w_accept;
    logic   w_rsp;

    // Outputs are also gated by the reset pin so that the request path is
    // quiet while reset is held, not only after the first clock edge.
    assign w_en      = cke_i & rst_n_i;
    assign w_idle    = (r_state == ST_IDLE);
    assign w_any_req = m0_avalid_i | m1_avalid_i;

    // ------------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------------
`ifdef IOB_BUS_ARBITER_ROUND_ROBIN_EN
    logic r_last_grant;
    logic w_last_grant_next;

    // Under contention, hand the bus to whoever was not served last;
    // a lone requester always wins.
    always_comb begin
        w_gnt = m1_avalid_i;
        if (m0_avalid_i && m1_avalid_i) begin
            w_gnt = ~r_last_grant;
        end
    end

    always_comb begin
        w_last_grant_next = r_last_grant;
        if (w_accept) begin
            w_last_grant_next = w_gnt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last_grant <= 1'b1;
        end else if (cke_i) begin
            r_last_grant <= w_last_grant_next;
        end
    end
`else
    // Fixed priority: the data bus (master 1) wins whenever it requests.
    // With no requester this resolves to master 0.
    assign w_gnt = m1_avalid_i;
`endif

    assign w_gnt_avalid  = w_gnt ? m1_avalid_i : m0_avalid_i;
    assign w_gnt_is_read = w_gnt ? (m1_wstrb_i == '0) : (m0_wstrb_i == '0);

    // ------------------------------------------------------------------------
    // Slave request path (purely combinational)
    // ------------------------------------------------------------------------
    assign s_avalid_o = w_idle & w_gnt_avalid & w_en;

    always_comb begin
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_wstrb_o = {STRB_W{1'b0}};
        if (w_idle && w_any_req) begin
            if (w_gnt) begin
                s_addr_o  = m1_addr_i;
                s_wdata_o = m1_wdata_i;
                s_wstrb_o = m1_wstrb_i;
            end else begin
                s_addr_o  = m0_addr_i;
                s_wdata_o = m0_wdata_i;
                s_wstrb_o = m0_wstrb_i;
            end
        end
    end

    assign m0_ready_o = s_ready_i & ~w_gnt & w_idle & w_en;
    assign m1_ready_o = s_ready_i &  w_gnt & w_idle & w_en;

    assign w_accept = s_avalid_o & s_ready_i;

    // ------------------------------------------------------------------------
    // Response path: data is broadcast, only the owner sees rvalid. Responses
    // arriving in IDLE (stray, or left over from a read abandoned by reset)
    // are discarded because no owner is waiting for them.
    // ------------------------------------------------------------------------
    assign w_rsp = (r_state == ST_RD_WAIT) & s_rvalid_i & w_en;

    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign m0_rvalid_o = w_rsp & ~r_owner;
    assign m1_rvalid_o = w_rsp &  r_owner;

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        case (r_state)
            ST_IDLE: begin
                // Writes leave us in IDLE so the next grant can follow
                // immediately; reads park the arbiter until the response.
                if (w_accept && w_gnt_is_read) begin
                    w_state_next = ST_RD_WAIT;
                    w_owner_next = w_gnt;
                end
            end
            ST_RD_WAIT: begin
                // Returning to IDLE here (rather than granting in the same
                // cycle) produces the one-cycle bubble after every read.
                if (w_rsp) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
        end else if (cke_i) begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iob_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_bus_arbiter
// Description : Self-checking bench for iob_bus_arbiter. Combinational IDLE
//               behaviour is swept from a vector table; multi-cycle cases
//               (reads, reset and clock-enable corner cases, contention) are
//               hand-written. Read responses are predicted into a queue and
//               checked as the DUT delivers them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [31:0] A0 = 32'h0000_0A00;
    localparam logic [31:0] A1 = 32'h0000_0B00;
    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0000;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              cke_i;
    logic              m0_avalid_i, m1_avalid_i;
    logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
    logic [DATA_W-1:0] m0_wdata_i, m1_wdata_i;
    logic [STRB_W-1:0] m0_wstrb_i, m1_wstrb_i;
    logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o;
    logic              m0_rvalid_o, m1_rvalid_o;
    logic              m0_ready_o, m1_ready_o;
    logic              s_avalid_o;
    logic [ADDR_W-1:0] s_addr_o;
    logic [DATA_W-1:0] s_wdata_o;
    logic [STRB_W-1:0] s_wstrb_o;
    logic [DATA_W-1:0] s_rdata_i;
    logic              s_rvalid_i;
    logic              s_ready_i;

    always #5 clk_i = ~clk_i;

    iob_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .cke_i       (cke_i),
        .m0_avalid_i (m0_avalid_i),
        .m0_addr_i   (m0_addr_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_wstrb_i  (m0_wstrb_i),
        .m0_rdata_o  (m0_rdata_o),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_ready_o  (m0_ready_o),
        .m1_avalid_i (m1_avalid_i),
        .m1_addr_i   (m1_addr_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_wstrb_i  (m1_wstrb_i),
        .m1_rdata_o  (m1_rdata_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_ready_o  (m1_ready_o),
        .s_avalid_o  (s_avalid_o),
        .s_addr_o    (s_addr_o),
        .s_wdata_o   (s_wdata_o),
        .s_wstrb_o   (s_wstrb_o),
        .s_rdata_i   (s_rdata_i),
        .s_rvalid_i  (s_rvalid_i),
        .s_ready_i   (s_ready_i)
    );

    typedef struct {
        logic        master;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic       m0v;
        logic [3:0] m0w;
        logic       m1v;
        logic [3:0] m1w;
        logic       sr;
        logic       cke;
        logic       sav;
        logic       r0;
        logic       r1;
        logic [1:0] sel;   // 0: slave data zero, 1: master 0, 2: master 1
    } vec_t;

    rsp_t sb[$];
    vec_t vt[8];
    int   total = 0;
    int   bad   = 0;
    logic lg;   // reference copy of the arbiter's last grant

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare any delivered response against the oldest predicted one.
    task automatic monitor();
        rsp_t e;
        if (m0_rvalid_o === 1'b1 || m1_rvalid_o === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rvalid: got m0=%b m1=%b want none (t=%0t)",
                         m0_rvalid_o, m1_rvalid_o, $time);
            end else begin
                e = sb.pop_front();
                check("rsp_m0_rvalid", {31'd0, m0_rvalid_o}, {31'd0, ~e.master});
                check("rsp_m1_rvalid", {31'd0, m1_rvalid_o}, {31'd0, e.master});
                check("rsp_rdata", e.master ? m1_rdata_o : m0_rdata_o, e.data);
            end
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        monitor();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic gnt_model(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef IOB_BUS_ARBITER_ROUND_ROBIN_EN
            return ~lg;
`else
            return 1'b1;
`endif
        end
        return v1;
    endfunction

    initial begin
        logic        eg;
        logic        e_r0, e_r1;
        logic [1:0]  e_sel;
        logic [31:0] ea, ed;
        logic [3:0]  ew;
        int          n0, n1, i0, i1;

        //           m0v   m0w   m1v   m1w   sr    cke   sav   r0    r1    sel
        vt[0] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vt[1] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1};
        vt[2] = '{1'b0, 4'h0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
        vt[3] = '{1'b1, 4'hF, 1'b1, 4'hC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
        vt[4] = '{1'b1, 4'h1, 1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2};
        vt[5] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
        vt[6] = '{1'b1, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
        vt[7] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2};

        // ---------------- reset with both masters requesting ----------------
        rst_n_i = 1'b0; cke_i = 1'b1; lg = 1'b1;
        m0_avalid_i = 1'b1; m0_addr_i = A0; m0_wdata_i = D0; m0_wstrb_i = 4'h0;
        m1_avalid_i = 1'b1; m1_addr_i = A1; m1_wdata_i = D1; m1_wstrb_i = 4'h0;
        s_ready_i = 1'b1; s_rvalid_i = 1'b1; s_rdata_i = 32'h1234_5678;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_s_avalid", {31'd0, s_avalid_o}, 32'd0);
        check("rst_m0_ready", {31'd0, m0_ready_o}, 32'd0);
        check("rst_m1_ready", {31'd0, m1_ready_o}, 32'd0);
        check("rst_m0_rvalid", {31'd0, m0_rvalid_o}, 32'd0);
        check("rst_m1_rvalid", {31'd0, m1_rvalid_o}, 32'd0);
        rst_n_i = 1'b1;
        #1;
        eg = gnt_model(1'b1, 1'b1);
        check("post_rst_s_avalid", {31'd0, s_avalid_o}, 32'd1);
        check("post_rst_m1_ready", {31'd0, m1_ready_o}, {31'd0, eg});
        check("post_rst_m0_ready", {31'd0, m0_ready_o}, {31'd0, ~eg});
        check("post_rst_idle_rv0", {31'd0, m0_rvalid_o}, 32'd0);
        check("post_rst_idle_rv1", {31'd0, m1_rvalid_o}, 32'd0);
        m0_avalid_i = 1'b0; m1_avalid_i = 1'b0; s_rvalid_i = 1'b0;

        // ---------------- combinational IDLE vectors ----------------
        for (int k = 0; k < 8; k++) begin
            m0_avalid_i = vt[k].m0v; m0_wstrb_i = vt[k].m0w;
            m1_avalid_i = vt[k].m1v; m1_wstrb_i = vt[k].m1w;
            m0_addr_i = A0; m1_addr_i = A1; m0_wdata_i = D0; m1_wdata_i = D1;
            s_ready_i = vt[k].sr; cke_i = vt[k].cke;
            e_r0 = vt[k].r0; e_r1 = vt[k].r1; e_sel = vt[k].sel;
            eg = gnt_model(vt[k].m0v, vt[k].m1v);
`ifdef IOB_BUS_ARBITER_ROUND_ROBIN_EN
            if (vt[k].m0v && vt[k].m1v) begin
                e_sel = eg ? 2'd2 : 2'd1;
                e_r0  = (vt[k].r0 | vt[k].r1) & ~eg;
                e_r1  = (vt[k].r0 | vt[k].r1) & eg;
            end
`endif
            ea = (e_sel == 2'd2) ? A1 : (e_sel == 2'd1) ? A0 : 32'd0;
            ed = (e_sel == 2'd2) ? D1 : (e_sel == 2'd1) ? D0 : 32'd0;
            ew = (e_sel == 2'd2) ? vt[k].m1w : (e_sel == 2'd1) ? vt[k].m0w : 4'h0;
            #1;
            check($sformatf("vec%0d_s_avalid", k), {31'd0, s_avalid_o}, {31'd0, vt[k].sav});
            check($sformatf("vec%0d_m0_ready", k), {31'd0, m0_ready_o}, {31'd0, e_r0});
            check($sformatf("vec%0d_m1_ready", k), {31'd0, m1_ready_o}, {31'd0, e_r1});
            check($sformatf("vec%0d_s_addr", k), s_addr_o, ea);
            check($sformatf("vec%0d_s_wdata", k), s_wdata_o, ed);
            check($sformatf("vec%0d_s_wstrb", k), {28'd0, s_wstrb_o}, {28'd0, ew});
            if (vt[k].sav && vt[k].sr) lg = eg;
            step();
        end
        m0_avalid_i = 1'b0; m1_avalid_i = 1'b0; cke_i = 1'b1;

        // ---------------- single read from master 0, 3-cycle slave ----------------
        m0_avalid_i = 1'b1; m0_addr_i = 32'h100; m0_wstrb_i = 4'h0; s_ready_i = 1'b1;
        #1;
        check("rd_s_avalid", {31'd0, s_avalid_o}, 32'd1);
        check("rd_m0_ready", {31'd0, m0_ready_o}, 32'd1);
        check("rd_s_addr", s_addr_o, 32'h100);
        lg = 1'b0;
        step();
        m0_avalid_i = 1'b0;
        m1_avalid_i = 1'b1; m1_wstrb_i = 4'hF; m1_addr_i = A1;
        #1;
        check("rdwait_s_avalid", {31'd0, s_avalid_o}, 32'd0);
        check("rdwait_m1_ready", {31'd0, m1_ready_o}, 32'd0);
        step();
        check("rdwait2_s_avalid", {31'd0, s_avalid_o}, 32'd0);
        step();
        s_rvalid_i = 1'b1; s_rdata_i = 32'hDEAD_BEEF;
        sb.push_back('{1'b0, 32'hDEAD_BEEF});
        #1;
        check("rd_m0_rvalid", {31'd0, m0_rvalid_o}, 32'd1);
        check("rd_m1_rvalid", {31'd0, m1_rvalid_o}, 32'd0);
        check("rd_m0_rdata", m0_rdata_o, 32'hDEAD_BEEF);
        check("rd_m1_rdata_bcast", m1_rdata_o, 32'hDEAD_BEEF);
        check("rd_bubble_s_avalid", {31'd0, s_avalid_o}, 32'd0);
        step();
        s_rvalid_i = 1'b0;
        #1;
        check("after_rd_m1_ready", {31'd0, m1_ready_o}, 32'd1);
        lg = 1'b1;
        step();
        m1_avalid_i = 1'b0;

        // ---------------- back-to-back writes from master 1 ----------------
        m1_avalid_i = 1'b1; m1_wstrb_i = 4'hF; m1_addr_i = 32'h10; m1_wdata_i = 32'hA;
        #1;
        check("wr1_m1_ready", {31'd0, m1_ready_o}, 32'd1);
        check("wr1_s_addr", s_addr_o, 32'h10);
        step();
        m1_addr_i = 32'h14; m1_wdata_i = 32'hB;
        #1;
        check("wr2_m1_ready", {31'd0, m1_ready_o}, 32'd1);
        check("wr2_s_addr", s_addr_o, 32'h14);
        check("wr2_s_wdata", s_wdata_o, 32'hB);
        step();
        m1_avalid_i = 1'b0;

        // ---------------- stray response in IDLE ----------------
        s_rvalid_i = 1'b1; s_rdata_i = 32'h5555_AAAA;
        #1;
        check("stray_m0_rvalid", {31'd0, m0_rvalid_o}, 32'd0);
        check("stray_m1_rvalid", {31'd0, m1_rvalid_o}, 32'd0);
        step();
        s_rvalid_i = 1'b0;

        // ---------------- contention: 4 reads each, 1-cycle slave ----------------
        n0 = 4; n1 = 4; i0 = 0; i1 = 0;
        m0_wstrb_i = 4'h0; m1_wstrb_i = 4'h0; s_ready_i = 1'b1;
        while (n0 > 0 || n1 > 0) begin
            m0_avalid_i = (n0 > 0); m1_avalid_i = (n1 > 0);
            m0_addr_i = 32'h200 + 32'(4 * i0);
            m1_addr_i = 32'h300 + 32'(4 * i1);
            #1;
            eg = gnt_model(m0_avalid_i, m1_avalid_i);
            ea = eg ? m1_addr_i : m0_addr_i;
            check("cont_m1_ready", {31'd0, m1_ready_o}, {31'd0, eg});
            check("cont_m0_ready", {31'd0, m0_ready_o}, {31'd0, ~eg});
            check("cont_s_addr", s_addr_o, ea);
            step();
            lg = eg;
            if (eg) begin n1--; i1++; end else begin n0--; i0++; end
            s_rvalid_i = 1'b1; s_rdata_i = ea ^ 32'hA5A5_0000;
            sb.push_back('{eg, ea ^ 32'hA5A5_0000});
            #1;
            check("cont_bubble_s_avalid", {31'd0, s_avalid_o}, 32'd0);
            step();
            s_rvalid_i = 1'b0;
        end
        m0_avalid_i = 1'b0; m1_avalid_i = 1'b0;

        // ---------------- reset while a read is outstanding ----------------
        m0_avalid_i = 1'b1; m0_addr_i = 32'h400; m0_wstrb_i = 4'h0;
        #1;
        check("rstrd_m0_ready", {31'd0, m0_ready_o}, 32'd1);
        step();
        m0_avalid_i = 1'b0;
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1; lg = 1'b1;
        s_rvalid_i = 1'b1; s_rdata_i = 32'hBAD0_BAD0;
        #1;
        check("late_rv_m0", {31'd0, m0_rvalid_o}, 32'd0);
        check("late_rv_m1", {31'd0, m1_rvalid_o}, 32'd0);
        step();
        s_rvalid_i = 1'b0;

        // ---------------- clock enable low during RD_WAIT ----------------
        m1_avalid_i = 1'b1; m1_addr_i = 32'h500; m1_wstrb_i = 4'h0;
        #1;
        check("cke_m1_ready", {31'd0, m1_ready_o}, 32'd1);
        step();
        lg = 1'b1;
        m1_avalid_i = 1'b0;
        cke_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'hCAFE_F00D;
        m0_avalid_i = 1'b1; m0_wstrb_i = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #0;
            check("cke_low_m1_rvalid", {31'd0, m1_rvalid_o}, 32'd0);
            check("cke_low_s_avalid", {31'd0, s_avalid_o}, 32'd0);
            step();
        end
        m0_avalid_i = 1'b0;
        cke_i = 1'b1;
        sb.push_back('{1'b1, 32'hCAFE_F00D});
        #1;
        check("cke_back_m1_rvalid", {31'd0, m1_rvalid_o}, 32'd1);
        step();
        s_rvalid_i = 1'b0;
        m0_avalid_i = 1'b1; m0_wstrb_i = 4'hF;
        #1;
        check("cke_idle_m0_ready", {31'd0, m0_ready_o}, 32'd1);
        step();
        m0_avalid_i = 1'b0;

        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Whole-run watchdog so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
